// File: rtl/tx_frame_buffer.sv
// Store-and-forward 64-bit AXI4-Stream frame buffer between the user-side register slice and a 10G MAC TX.
// Optional macro TX_FRAME_STATS_EN adds tx_frames_sent / tx_frames_dropped counters.
module tx_frame_buffer #(
    parameter int unsigned DEPTH_LOG2    = 9,
    parameter int unsigned MAX_PKTS_LOG2 = 6
) (
    input  logic        user_clk,
    input  logic        reset,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        frame_dropped
`ifdef TX_FRAME_STATS_EN
    ,
    output logic [31:0] tx_frames_sent,
    output logic [31:0] tx_frames_dropped
`endif
);

    localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;
    localparam int unsigned WORD_W = 73;
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {ACCEPT, DROP} wr_state_t;
    typedef enum logic {IDLE, SEND} rd_state_t;

    logic [WORD_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    wr_state_t          wr_state;
    rd_state_t          rd_state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_commit;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   occupancy;
    logic [MAX_PKTS_LOG2-1:0] pkt_count;
    logic [MAX_PKTS_LOG2-1:0] pkt_next;
    logic               ready_en;
    logic               pf_valid;
    logic [WORD_W-1:0]  pf_word;
    logic [WORD_W-1:0]  out_word;

    logic buf_full, pkt_full, s_accept, wr_en, commit, drop_done;
    logic m_fire, frame_out, out_load, fetch;

    always_comb begin
        occupancy     = wr_ptr - rd_ptr;
        buf_full      = (occupancy == DEPTH);
        pkt_full      = &pkt_count;
        s_axis_tready = ready_en && ((wr_state == DROP) || (!buf_full && !pkt_full));
        s_accept      = s_axis_tvalid && s_axis_tready;
        wr_en         = s_accept && (wr_state == ACCEPT);
        commit        = wr_en && s_axis_tlast;
        drop_done     = s_accept && (wr_state == DROP) && s_axis_tlast;
        m_fire        = m_axis_tvalid && m_axis_tready;
        frame_out     = m_fire && m_axis_tlast;
        // Prefetch only ever pulls committed beats, so whole frames reach the MAC without gaps.
        out_load      = pf_valid && (!m_axis_tvalid || m_axis_tready);
        fetch         = (rd_ptr != wr_commit) && (!pf_valid || out_load);
        pkt_next      = pkt_count;
        if (commit && !frame_out)
            pkt_next = pkt_count + MAX_PKTS_LOG2'(1);
        else if (!commit && frame_out)
            pkt_next = pkt_count - MAX_PKTS_LOG2'(1);
    end

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_word;

    always_ff @(posedge user_clk) begin
        if (wr_en)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (fetch)
            pf_word <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            wr_state      <= ACCEPT;
            rd_state      <= IDLE;
            wr_ptr        <= '0;
            wr_commit     <= '0;
            rd_ptr        <= '0;
            pkt_count     <= '0;
            ready_en      <= 1'b0;
            pf_valid      <= 1'b0;
            out_word      <= '0;
            m_axis_tvalid <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            ready_en      <= 1'b1;
            pkt_count     <= pkt_next;
            frame_dropped <= drop_done;

            case (wr_state)
                ACCEPT: begin
                    if (buf_full && s_axis_tvalid && (pkt_count == '0)) begin
                        // Frame cannot fit even in an empty buffer: discard what was written.
                        wr_state <= DROP;
                        wr_ptr   <= wr_commit;
                    end else if (wr_en) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        if (s_axis_tlast)
                            wr_commit <= wr_ptr + PTR_W'(1);
                    end
                end
                DROP: begin
                    if (drop_done)
                        wr_state <= ACCEPT;
                end
                default: wr_state <= ACCEPT;
            endcase

            case (rd_state)
                IDLE:    if (pkt_count != '0) rd_state <= SEND;
                SEND:    if (frame_out && (pkt_next == '0)) rd_state <= IDLE;
                default: rd_state <= IDLE;
            endcase

            if (fetch) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                pf_valid <= 1'b1;
            end else if (out_load) begin
                pf_valid <= 1'b0;
            end

            if (out_load) begin
                out_word      <= pf_word;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef TX_FRAME_STATS_EN
    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            tx_frames_sent    <= '0;
            tx_frames_dropped <= '0;
        end else begin
            if (frame_out)
                tx_frames_sent <= tx_frames_sent + 32'd1;
            if (drop_done)
                tx_frames_dropped <= tx_frames_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Self-checking bench for tx_frame_buffer (DEPTH_LOG2=4): cycle table for a single frame plus multi-cycle sequences.
module tb_tx_frame_buffer;

    localparam int unsigned DL2 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tlast, s_ready;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_valid, m_last, m_ready;
    logic        fd;
`ifdef TX_FRAME_STATS_EN
    logic [31:0] st_sent, st_dropped;
`endif

    tx_frame_buffer #(.DEPTH_LOG2(DL2), .MAX_PKTS_LOG2(6)) dut (
        .user_clk      (clk),
        .reset         (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tkeep  (m_keep),
        .m_axis_tvalid (m_valid),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .frame_dropped (fd)
`ifdef TX_FRAME_STATS_EN
        ,
        .tx_frames_sent    (st_sent),
        .tx_frames_dropped (st_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv, sl, mr;
        logic [7:0]  sk;
        logic [63:0] sd;
        logic        e_sr, e_mv, e_ml, e_fd;
        logic [7:0]  e_mk;
        logic [63:0] e_md;
    } vec_t;

    vec_t        tbl [19];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          fd_cnt = 0;
    int          mv_cnt = 0;
    logic [72:0] exp_q [$];
    logic [72:0] out_q [$];
    int          out_cyc [$];
    bit          stab_en = 1'b0;
    bit          held = 1'b0;
    bit          in_frame = 1'b0;
    logic [72:0] held_word = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                out_q.push_back({m_last, m_keep, m_data});
                out_cyc.push_back(cyc);
            end
            if (m_valid) mv_cnt++;
            if (fd) fd_cnt++;
            if (stab_en) begin
                if (held) chk("stall_hold_word", 128'({m_last, m_keep, m_data}), 128'(held_word));
                if (in_frame) chk("valid_continuous", 128'(m_valid), 128'(1));
                held = m_valid && !m_ready;
                held_word = {m_last, m_keep, m_data};
                if (m_valid) in_frame = !(m_ready && m_last);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                              input int max_wait, output bit ok);
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1; ok = 1'b0;
        for (int w = 0; w < max_wait && !ok; w++) begin
            if (s_ready) ok = 1'b1;
            tick();
        end
        if (ok) s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [63:0] base, input logic [7:0] lk, input bit fwd);
        bit ok;
        logic [7:0] k;
        for (int i = 0; i < n; i++) begin
            k = (i == n - 1) ? lk : 8'hFF;
            drive_beat(base + 64'(i), k, i == n - 1, 100, ok);
            if (!ok) chk("accept_timeout", 128'(0), 128'(1));
            if (fwd) exp_q.push_back({i == n - 1, k, base + 64'(i)});
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_out(input int n, input int bound);
        for (int w = 0; w < bound && out_q.size() < n; w++) tick();
        repeat (5) tick();
        chk("out_beat_count", 128'(out_q.size()), 128'(n));
    endtask

    task automatic cmp_q(input string nm);
        chk({nm, "_len"}, 128'(out_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            chk(nm, 128'(out_q[i]), 128'(exp_q[i]));
        out_q.delete(); out_cyc.delete(); exp_q.delete();
    endtask

    initial begin
        bit ok;
        s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_ready = 1'b1;
        rst = 1'b1;

        // One 8-beat frame, last keep 0F: first output beat two cycles after the tlast handshake.
        for (int i = 0; i < 19; i++) begin
            tbl[i].sv   = (i < 8);
            tbl[i].sl   = (i == 7);
            tbl[i].sk   = (i == 7) ? 8'h0F : 8'hFF;
            tbl[i].sd   = (i < 8) ? 64'h1000 + 64'(i) : 64'h0;
            tbl[i].mr   = 1'b1;
            tbl[i].e_sr = 1'b1;
            tbl[i].e_mv = (i >= 10 && i <= 17);
            tbl[i].e_md = 64'h1000 + 64'(i - 10);
            tbl[i].e_mk = (i == 17) ? 8'h0F : 8'hFF;
            tbl[i].e_ml = (i == 17);
            tbl[i].e_fd = 1'b0;
        end

        repeat (2) tick();
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_m_last", 128'(m_last), 128'(0));
        chk("rst_m_data", 128'(m_data), 128'(0));
        chk("rst_m_keep", 128'(m_keep), 128'(0));
        chk("rst_dropped", 128'(fd), 128'(0));
        rst = 1'b0;
        #1;
        chk("ready_before_edge", 128'(s_ready), 128'(0));
        tick();
        chk("ready_after_edge", 128'(s_ready), 128'(1));

        for (int i = 0; i < 19; i++) begin
            s_tvalid = tbl[i].sv; s_tlast = tbl[i].sl; s_tkeep = tbl[i].sk;
            s_tdata = tbl[i].sd; m_ready = tbl[i].mr;
            @(negedge clk);
            chk("tbl_s_ready", 128'(s_ready), 128'(tbl[i].e_sr));
            chk("tbl_m_valid", 128'(m_valid), 128'(tbl[i].e_mv));
            chk("tbl_dropped", 128'(fd), 128'(tbl[i].e_fd));
            if (tbl[i].e_mv) begin
                chk("tbl_m_data", 128'(m_data), 128'(tbl[i].e_md));
                chk("tbl_m_keep", 128'(m_keep), 128'(tbl[i].e_mk));
                chk("tbl_m_last", 128'(m_last), 128'(tbl[i].e_ml));
            end
            tick();
        end
        out_q.delete(); out_cyc.delete();

        // Two 4-beat frames back to back.
        send_frame(4, 64'h2000, 8'h03, 1'b1);
        send_frame(4, 64'h3000, 8'h7F, 1'b1);
        wait_out(8, 60);
        for (int i = 0; i < out_cyc.size(); i++)
            chk("b2b_no_gap", 128'(out_cyc[i] - out_cyc[0]), 128'(i));
        cmp_q("b2b_beat");

        // Oversize frame (20 beats > 16) is dropped, next frame forwarded.
        fd_cnt = 0; mv_cnt = 0;
        send_frame(20, 64'h4000, 8'hFF, 1'b0);
        repeat (4) tick();
        chk("drop_pulse_count", 128'(fd_cnt), 128'(1));
        chk("drop_no_valid", 128'(mv_cnt), 128'(0));
`ifdef TX_FRAME_STATS_EN
        chk("stat_dropped", 128'(st_dropped), 128'(1));
`endif
        send_frame(3, 64'h5000, 8'h01, 1'b1);
        wait_out(3, 40);
        cmp_q("after_drop_beat");

        // Full buffer with stored frames stalls, never drops.
        fd_cnt = 0;
        m_ready = 1'b0;
        send_frame(8, 64'h6000, 8'hFF, 1'b1);
        send_frame(8, 64'h7000, 8'h0F, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive_beat(64'h8800 + 64'(i), 8'hFF, 1'b0, 100, ok);
            chk("fill_accept", 128'(ok), 128'(1));
            exp_q.push_back({1'b0, 8'hFF, 64'h8800 + 64'(i)});
        end
        drive_beat(64'h8802, 8'hFF, 1'b0, 20, ok);
        chk("full_stall", 128'(ok), 128'(0));
        chk("full_s_ready", 128'(s_ready), 128'(0));
        chk("full_no_drop", 128'(fd_cnt), 128'(0));
        chk("full_no_output", 128'(out_q.size()), 128'(0));
        m_ready = 1'b1;
        drive_beat(64'h8802, 8'hFF, 1'b0, 100, ok);
        chk("release_accept", 128'(ok), 128'(1));
        drive_beat(64'h8803, 8'h3C, 1'b1, 100, ok);
        chk("release_accept_last", 128'(ok), 128'(1));
        exp_q.push_back({1'b0, 8'hFF, 64'h8802});
        exp_q.push_back({1'b1, 8'h3C, 64'h8803});
        wait_out(20, 80);
        cmp_q("full_order_beat");

        // Toggling m_axis_tready: tvalid held, data stable on stalls.
        m_ready = 1'b0;
        send_frame(6, 64'h9000, 8'h3F, 1'b1);
        repeat (3) tick();
        chk("toggle_pre_valid", 128'(m_valid), 128'(1));
        stab_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            m_ready = (i % 2 == 0);
            tick();
        end
        stab_en = 1'b0;
        m_ready = 1'b1;
        wait_out(6, 20);
        cmp_q("toggle_beat");

        // Reset mid-output with a second frame stored.
        m_ready = 1'b0;
        send_frame(5, 64'hA000, 8'hFF, 1'b0);
        send_frame(3, 64'hB000, 8'hFF, 1'b0);
        repeat (3) tick();
        m_ready = 1'b1;
        repeat (2) tick();
        m_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_m_valid", 128'(m_valid), 128'(0));
        chk("arst_m_last", 128'(m_last), 128'(0));
        chk("arst_m_data", 128'(m_data), 128'(0));
        chk("arst_m_keep", 128'(m_keep), 128'(0));
        chk("arst_s_ready", 128'(s_ready), 128'(0));
`ifdef TX_FRAME_STATS_EN
        chk("arst_stat_sent", 128'(st_sent), 128'(0));
        chk("arst_stat_dropped", 128'(st_dropped), 128'(0));
`endif
        tick();
        rst = 1'b0;
        tick();
        out_q.delete(); out_cyc.delete(); exp_q.delete();
        mv_cnt = 0;
        m_ready = 1'b1;
        repeat (4) tick();
        chk("post_rst_empty", 128'(mv_cnt), 128'(0));
        send_frame(2, 64'hC000, 8'h07, 1'b1);
        wait_out(2, 40);
        cmp_q("post_rst_beat");
`ifdef TX_FRAME_STATS_EN
        chk("post_rst_stat_sent", 128'(st_sent), 128'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_frame_buffer.md
TX_FRAME_BUFFER -- requirements
Module: tx_frame_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 9, log2 of buffer depth in 64-bit beats; depth = 2^DEPTH_LOG2.
REQ-002 Parameter MAX_PKTS_LOG2, default 6, width of the stored-frame counter.
REQ-003 user_clk  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 s_axis_tdata  in  64  frame data from the user-side register slice.
REQ-006 s_axis_tkeep  in  8  byte enables.
REQ-007 s_axis_tvalid / s_axis_tlast  in  1 each  AXI4-Stream valid / end of frame.
REQ-008 s_axis_tready  out  1  buffer accepts a beat.
REQ-009 m_axis_tdata  out  64  data to the 10G MAC TX.
REQ-010 m_axis_tkeep  out  8  byte enables to MAC.
REQ-011 m_axis_tvalid / m_axis_tlast  out  1 each  valid / end of frame to MAC.
REQ-012 m_axis_tready  in  1  MAC ready.
REQ-013 frame_dropped  out  1  one-cycle pulse per discarded oversize frame.

Function
REQ-014 The block SHALL store each frame completely before presenting any beat of it to the MAC (store-and-forward), so the MAC never sees a mid-frame tvalid gap.
REQ-015 Storage: 2^DEPTH_LOG2 x 73-bit RAM {tlast, tkeep, tdata}; pointers one bit wider than the address; wrap-around by natural overflow.
REQ-016 Write side keeps wr_ptr (speculative) and wr_commit; each accepted beat writes at wr_ptr and increments it; an accepted tlast beat copies wr_ptr+1 into wr_commit and increments pkt_count.
REQ-017 s_axis_tready SHALL be 1 when (wr_ptr - rd_ptr) < depth, or when in state DROP; 0 during reset.
REQ-018 Write FSM states ACCEPT, DROP; ACCEPT->DROP when buffer full, s_axis_tvalid=1 and pkt_count=0 (frame larger than buffer); on entry wr_ptr rewinds to wr_commit.
REQ-019 In DROP every beat is accepted and discarded; DROP->ACCEPT on the accepted tlast beat, which SHALL pulse frame_dropped for one cycle.
REQ-020 A full buffer with pkt_count>0 SHALL only stall (tready=0), never drop.
REQ-021 Read FSM states IDLE, SEND; IDLE->SEND when pkt_count>0; SEND->IDLE on m_axis handshake with m_axis_tlast=1, unless pkt_count after update >0, in which case it stays in SEND.
REQ-022 Output is a registered stage with one-beat prefetch; first beat of a frame SHALL appear on m_axis_tvalid 2 cycles after the tlast beat is accepted on s_axis (buffer previously empty).
REQ-023 In SEND, m_axis_tvalid SHALL stay 1 from first beat until the tlast handshake; data/tkeep/tlast SHALL be held stable while tvalid=1 and tready=0.
REQ-024 Back-to-back frames SHALL stream with zero idle cycles between tlast and the next first beat when already stored.
REQ-025 pkt_count decrements on the output tlast handshake; simultaneous increment and decrement SHALL leave it unchanged; write side stalls (tready=0) if pkt_count is at its maximum.
REQ-026 Throughput: one beat per cycle on each side concurrently.

Reset
REQ-027 Asserting reset SHALL immediately clear wr_ptr, wr_commit, rd_ptr, pkt_count, both FSMs (ACCEPT, IDLE), and drive s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, frame_dropped=0.
REQ-028 Reset mid-frame SHALL discard all stored and partial frames; RAM contents need not be cleared.
REQ-029 s_axis_tready SHALL rise no earlier than the first clock edge after reset deassertion.

Configuration
REQ-030 Macro TX_FRAME_STATS_EN: when defined, add outputs tx_frames_sent[31:0] (increments per output tlast handshake) and tx_frames_dropped[31:0] (increments per frame_dropped pulse), both wrapping, cleared by reset.
REQ-031 Without TX_FRAME_STATS_EN those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 One 8-beat frame, m_axis_tready=1 -> no m_axis_tvalid before s tlast; 8 contiguous beats starting 2 cycles after tlast, data/tkeep match, last tkeep preserved (e.g. 8'h0F).
REQ-033 Two 4-beat frames back-to-back, tready=1 -> 8 output beats, no gap, tlast at beats 4 and 8.
REQ-034 DEPTH_LOG2=4, 20-beat frame into empty buffer -> frame_dropped pulses once after beat 20, no m_axis_tvalid; following 3-beat frame forwarded intact.
REQ-035 Fill buffer with 2 frames, hold m_axis_tready=0 -> s_axis_tready=0 when full, no drop; release tready -> all frames emitted in order.
REQ-036 m_axis_tready toggling 1/0 each cycle during a 6-beat frame -> tvalid continuously 1, outputs stable on stalls.
REQ-037 Reset asserted mid-output of frame 1 with frame 2 stored -> outputs zero asynchronously; after release buffer empty, new frame passes normally; with TX_FRAME_STATS_EN counters read 0.
